// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: redirect/stall controls, instruction memory handshake and delivered instruction.
// The master modport is the sequencer; the slave modport is its environment.
interface fetch_sequencer_if;
    logic        stall;
    logic        is_call;
    logic        is_auipc;
    logic        should_branch;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc;

    modport master (
        input  stall, is_call, is_auipc, should_branch, branch_address, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr_valid, instr, instr_pc, pc
    );

    modport slave (
        output stall, is_call, is_auipc, should_branch, branch_address, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one memory request at a time, delivers or holds the
// returned word, and steers the PC on redirects (including ones that arrive mid-request).
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic        redirect;
    logic [31:0] pc_inc;
    logic        imem_req;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    assign redirect = bus.is_call | bus.is_auipc | bus.should_branch;
    assign pc_inc   = pc_q + 32'd4;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        pend_addr_d  = pend_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        instr        = hold_instr_q;
        instr_pc     = hold_pc_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redirect) pc_d = bus.branch_address;
            end
            ST_REQ: begin
                imem_req = 1'b1;
                instr    = bus.imem_rdata;
                instr_pc = pc_q;
                if (bus.imem_ack) begin
                    if (drop_q || redirect) begin
                        // Returned word belongs to the abandoned path.
                        pc_d   = redirect ? bus.branch_address : pend_addr_q;
                        drop_d = 1'b0;
                    end else if (!bus.stall) begin
                        instr_valid = 1'b1;
                        pc_d        = pc_inc;
                    end else begin
                        hold_instr_d = bus.imem_rdata;
                        hold_pc_d    = pc_q;
                        state_d      = ST_HOLD;
                    end
                end else if (redirect) begin
                    // Request cannot be withdrawn; remember where to go once it completes.
                    drop_d      = 1'b1;
                    pend_addr_d = bus.branch_address;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = bus.branch_address;
                    state_d = ST_REQ;
                end else begin
                    instr_valid = 1'b1;
                    if (!bus.stall) begin
                        pc_d    = pc_inc;
                        state_d = ST_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            pend_addr_q  <= 32'h0;
            hold_instr_q <= 32'h0;
            hold_pc_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            pend_addr_q  <= pend_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign bus.imem_req    = imem_req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid;
    assign bus.instr       = instr;
    assign bus.instr_pc    = instr_pc;
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: inputs change 1ns after a rising edge, outputs are
// checked 1ns later, well before the next edge.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic stall,
                         input logic call, input logic auipc, input logic br,
                         input logic [31:0] target);
        bus.imem_ack       = ack;
        bus.imem_rdata     = rdata;
        bus.stall          = stall;
        bus.is_call        = call;
        bus.is_auipc       = auipc;
        bus.should_branch  = br;
        bus.branch_address = target;
        #1;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("rst_req", {31'b0, bus.imem_req}, 32'h0);
        check("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        check("rst_pc", bus.pc, 32'h0);

        // Release; an ack while idle must be ignored.
        rst = 1'b0;
        drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("idle_req", {31'b0, bus.imem_req}, 32'h0);
        check("idle_ack_ignored", {31'b0, bus.instr_valid}, 32'h0);
        tick();

        // Sequential fetch, ack every REQ cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            check("seq_req", {31'b0, bus.imem_req}, 32'h1);
            check("seq_addr", bus.imem_addr, 32'(i * 4));
            check("seq_valid", {31'b0, bus.instr_valid}, 32'h1);
            check("seq_instr", bus.instr, 32'(i * 4));
            check("seq_instr_pc", bus.instr_pc, 32'(i * 4));
            tick();
        end

        // pc=0xC: branch coincident with ack -> discarded, go to 0x100.
        drive(1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        check("br_ack_addr", bus.imem_addr, 32'hC);
        check("br_ack_novalid", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_000C);
        check("br_target", bus.imem_addr, 32'h100);
        check("br_again_novalid", {31'b0, bus.instr_valid}, 32'h0);
        tick();

        // Back at 0xC: call, then auipc before ack; latest target wins.
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200);
        check("call_addr", bus.imem_addr, 32'hC);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("no_withdraw_req", {31'b0, bus.imem_req}, 32'h1);
        check("no_withdraw_addr", bus.imem_addr, 32'hC);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300);
        tick();
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("drop_novalid", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
        check("pend_target", bus.imem_addr, 32'h300);
        tick();

        // pc=0x10: stall through ack and three HOLD cycles, release on the fourth.
        drive(1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("stall_addr", bus.imem_addr, 32'h10);
        check("stall_ack_novalid", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hBAD0_0000, (i < 3), 1'b0, 1'b0, 1'b0, 32'h0);
            check("hold_valid", {31'b0, bus.instr_valid}, 32'h1);
            check("hold_instr_pc", bus.instr_pc, 32'h10);
            check("hold_instr", bus.instr, 32'h10);
            check("hold_req", {31'b0, bus.imem_req}, 32'h0);
            tick();
        end
        drive(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("after_hold_addr", bus.imem_addr, 32'h14);
        check("after_hold_req", {31'b0, bus.imem_req}, 32'h1);
        tick();

        // HOLD with redirect and stall: redirect wins.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        check("hold_br_novalid", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        drive(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("hold_br_addr", bus.imem_addr, 32'h40);
        check("hold_br_req", {31'b0, bus.imem_req}, 32'h1);
        tick();

        // Wrap at top of address space.
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
        check("wrap_instr", bus.instr, 32'h1234_5678);
        check("wrap_valid", {31'b0, bus.instr_valid}, 32'h1);
        tick();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20);
        check("wrap_addr", bus.imem_addr, 32'h0);
        tick();

        // Reset during an outstanding request at 0x20.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("pre_rst_addr", bus.imem_addr, 32'h20);
        rst = 1'b1;
        #1;
        check("async_rst_req", {31'b0, bus.imem_req}, 32'h0);
        check("async_rst_pc", bus.pc, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("restart_idle_req", {31'b0, bus.imem_req}, 32'h0);
        tick();
        check("restart_req", {31'b0, bus.imem_req}, 32'h1);
        check("restart_addr", bus.imem_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
